// File: rtl/tw_rom_seq_ctrl_if.sv
// Host-side twiddle stream: 64-bit half-words offered with valid, taken when ready.
interface tw_rom_seq_ctrl_if #(
  parameter int DW = 64
);
  logic [DW-1:0] hdata;
  logic          hdata_valid;
  logic          hdata_ready;

  modport master (output hdata, output hdata_valid, input hdata_ready);
  modport slave  (input hdata, input hdata_valid, output hdata_ready);
endinterface

// File: rtl/tw_rom_seq_ctrl.sv
// Twiddle ROM sequencer: buffers host half-words, replays them as one contiguous
// horizontal-write burst, then walks stage_counter/CEN/state through every stage.
module tw_rom_seq_ctrl #(
  parameter int SC_WIDTH      = 3,
  parameter int S_WIDTH       = 4,
  parameter int horizontal_DW = 64,
  parameter int NUM_STAGE     = 3,
  parameter int STAGE_LEN     = 256,
  parameter int LOAD_WORDS    = 4
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     load_en,
  input  logic                     hold,
  tw_rom_seq_ctrl_if.slave         host,
  output logic [SC_WIDTH-1:0]      stage_counter,
  output logic                     CEN,
  output logic [S_WIDTH-1:0]       state,
  output logic [1:0]               ROM3_w,
  output logic [horizontal_DW-1:0] horizontal_data_out,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
  localparam int BEATS = 2 * LOAD_WORDS;
  localparam logic [2:0]          LAST_BEAT  = 3'(BEATS - 1);
  localparam logic [2:0]          LO_START   = 3'(LOAD_WORDS);
  localparam logic [CW-1:0]       LAST_CYC   = CW'(STAGE_LEN - 1);
  localparam logic [CW-1:0]       HALF_CYC   = CW'(STAGE_LEN / 2);
  localparam logic [SC_WIDTH-1:0] LAST_STAGE = SC_WIDTH'(NUM_STAGE - 1);
  localparam logic [S_WIDTH-1:0]  ST_FIRST   = S_WIDTH'(4);
  localparam logic [S_WIDTH-1:0]  ST_SECOND  = S_WIDTH'(6);

  typedef enum logic [2:0] {IDLE, COLLECT, BURST, RUN, GAP, FIN} fsm_e;

  fsm_e                     fsm_q, fsm_d;
  logic [2:0]               beat_q, beat_d;
  logic [2:0]               burst_q, burst_d;
  logic [CW-1:0]            cyc_q, cyc_d;
  logic [SC_WIDTH-1:0]      stage_q, stage_d;
  logic                     active_d;
  logic                     accept;

  logic                     cen_q, cen_d;
  logic [SC_WIDTH-1:0]      sc_q, sc_d;
  logic [S_WIDTH-1:0]       st_q, st_d;
  logic [1:0]               romw_q, romw_d;
  logic [horizontal_DW-1:0] hdo_q, hdo_d;
  logic                     hready_q, hready_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic [horizontal_DW-1:0] hbuf_q [BEATS];

  assign accept = (fsm_q == COLLECT) && hready_q && host.hdata_valid;

  always_ff @(posedge CLK) begin
    if (rst) begin
      fsm_q    <= IDLE;
      beat_q   <= '0;
      burst_q  <= '0;
      cyc_q    <= '0;
      stage_q  <= '0;
      cen_q    <= 1'b1;
      sc_q     <= '0;
      st_q     <= '0;
      romw_q   <= '0;
      hdo_q    <= '0;
      hready_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      beat_q   <= beat_d;
      burst_q  <= burst_d;
      cyc_q    <= cyc_d;
      stage_q  <= stage_d;
      cen_q    <= cen_d;
      sc_q     <= sc_d;
      st_q     <= st_d;
      romw_q   <= romw_d;
      hdo_q    <= hdo_d;
      hready_q <= hready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      hbuf_q[beat_q] <= host.hdata;
    end
  end

  // In RUN, cyc_q is the cyc of the last active cycle, so a held cycle simply
  // repeats it and the stage-end transition waits for the next un-held edge.
  always_comb begin
    fsm_d    = fsm_q;
    beat_d   = beat_q;
    burst_d  = burst_q;
    cyc_d    = cyc_q;
    stage_d  = stage_q;
    active_d = 1'b0;
    case (fsm_q)
      IDLE: begin
        if (start) begin
          if (load_en) begin
            fsm_d  = COLLECT;
            beat_d = '0;
          end else begin
            fsm_d    = RUN;
            cyc_d    = '0;
            stage_d  = '0;
            active_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (accept) begin
          if (beat_q == LAST_BEAT) begin
            fsm_d   = BURST;
            beat_d  = '0;
            burst_d = '0;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      BURST: begin
        if (burst_q == LAST_BEAT) begin
          fsm_d    = RUN;
          burst_d  = '0;
          cyc_d    = '0;
          stage_d  = '0;
          active_d = 1'b1;
        end else begin
          burst_d = burst_q + 3'd1;
        end
      end
      RUN: begin
        if (!hold) begin
          if (cyc_q == LAST_CYC) begin
            cyc_d = '0;
            if (stage_q == LAST_STAGE) begin
              fsm_d   = FIN;
              stage_d = '0;
            end else begin
              fsm_d = GAP;
            end
          end else begin
            cyc_d    = cyc_q + CW'(1);
            active_d = 1'b1;
          end
        end
      end
      GAP: begin
        fsm_d    = RUN;
        stage_d  = stage_q + SC_WIDTH'(1);
        cyc_d    = '0;
        active_d = 1'b1;
      end
      FIN: begin
        fsm_d   = IDLE;
        stage_d = '0;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // Outputs are derived from the next-state values so every port comes straight from a flop.
  always_comb begin
    cen_d    = ~active_d;
    sc_d     = '0;
    st_d     = '0;
    romw_d   = 2'd0;
    hdo_d    = '0;
    hready_d = (fsm_d == COLLECT);
    busy_d   = (fsm_d != IDLE);
    done_d   = (fsm_d == FIN);
    if (fsm_d == RUN || fsm_d == GAP) begin
      sc_d = stage_d;
    end
    if (fsm_d == RUN) begin
      st_d = (cyc_d < HALF_CYC) ? ST_FIRST : ST_SECOND;
    end
    if (fsm_d == BURST) begin
      romw_d = (burst_d < LO_START) ? 2'd1 : 2'd2;
      hdo_d  = hbuf_q[burst_d];
    end
  end

  assign host.hdata_ready    = hready_q;
  assign stage_counter       = sc_q;
  assign CEN                 = cen_q;
  assign state               = st_q;
  assign ROM3_w              = romw_q;
  assign horizontal_data_out = hdo_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: tb/tb_tw_rom_seq_ctrl.sv
// Directed bench for tw_rom_seq_ctrl with STAGE_LEN=8, NUM_STAGE=3 and a small ROM write model.
module tb_tw_rom_seq_ctrl;
  localparam int SCW = 3;
  localparam int SW  = 4;
  localparam int DW  = 64;
  localparam int NS  = 3;
  localparam int SL  = 8;
  localparam int LW  = 4;

  logic           CLK = 1'b0;
  logic           rst;
  logic           start;
  logic           load_en;
  logic           hold;
  logic [SCW-1:0] stage_counter;
  logic           CEN;
  logic [SW-1:0]  state;
  logic [1:0]     ROM3_w;
  logic [DW-1:0]  horizontal_data_out;
  logic           busy;
  logic           done;

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [DW-1:0] rom_hi [4];
  logic [DW-1:0] rom_lo [4];
  int hptr = 0;
  int lptr = 0;

  tw_rom_seq_ctrl_if #(.DW(DW)) host_if ();

  tw_rom_seq_ctrl #(
    .SC_WIDTH(SCW), .S_WIDTH(SW), .horizontal_DW(DW),
    .NUM_STAGE(NS), .STAGE_LEN(SL), .LOAD_WORDS(LW)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .load_en(load_en), .hold(hold),
    .host(host_if), .stage_counter(stage_counter), .CEN(CEN), .state(state),
    .ROM3_w(ROM3_w), .horizontal_data_out(horizontal_data_out),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // ROM model: separate high/low horizontal pointers that clear on any non-write cycle.
  always @(negedge CLK) begin
    if (ROM3_w == 2'd1) begin
      if (hptr < 4) rom_hi[hptr] = horizontal_data_out;
      hptr = hptr + 1;
      lptr = 0;
    end else if (ROM3_w == 2'd2) begin
      if (lptr < 4) rom_lo[lptr] = horizontal_data_out;
      lptr = lptr + 1;
    end else begin
      hptr = 0;
      lptr = 0;
    end
  end

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    logic [12:0] got;
    rst = 1'b1; start = 1'b0; load_en = 1'b0; hold = 1'b0;
    host_if.hdata = '0; host_if.hdata_valid = 1'b0;
    step; step;
    rst = 1'b0;
    got = {CEN, stage_counter, state, ROM3_w, host_if.hdata_ready, busy, done};
    vec_cnt++;
    if (got !== 13'b1_000_0000_00_0_0_0) begin
      err_cnt++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", got, 13'b1_000_0000_00_0_0_0);
    end
    vec_cnt++;
    if (horizontal_data_out !== '0) begin
      err_cnt++;
      $display("[TB] FAIL reset_hdo: got %h expected 0", horizontal_data_out);
    end
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (11) step;
    vec_cnt++;
    if ({CEN, stage_counter} !== {1'b0, 3'd1}) begin
      err_cnt++;
      $display("[TB] FAIL midrun_stage1: got CEN=%b sc=%0d expected CEN=0 sc=1", CEN, stage_counter);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    got = {CEN, stage_counter, state, ROM3_w, host_if.hdata_ready, busy, done};
    vec_cnt++;
    if (got !== 13'b1_000_0000_00_0_0_0) begin
      err_cnt++;
      $display("[TB] FAIL midrun_reset: got %b expected %b", got, 13'b1_000_0000_00_0_0_0);
    end
    step;
    vec_cnt++;
    if ({busy, CEN} !== 2'b01) begin
      err_cnt++;
      $display("[TB] FAIL post_reset_idle: got busy=%b CEN=%b expected busy=0 CEN=1", busy, CEN);
    end
  endtask

  task automatic test_plain_run;
    logic [9:0] got, exp;
    int p, s, r;
    start = 1'b1; load_en = 1'b0;
    step;
    start = 1'b0;
    for (int n = 1; n <= 28; n++) begin
      if (n == 28) begin
        exp = {1'b1, 4'd0, 3'd0, 1'b0, 1'b0};
      end else if (n == 27) begin
        exp = {1'b1, 4'd0, 3'd0, 1'b1, 1'b1};
      end else begin
        p = n - 1; s = p / 9; r = p % 9;
        if (r == 8) exp = {1'b1, 4'd0, 3'(s), 1'b0, 1'b1};
        else        exp = {1'b0, (r < 4) ? 4'd4 : 4'd6, 3'(s), 1'b0, 1'b1};
      end
      got = {CEN, state, stage_counter, done, busy};
      vec_cnt++;
      if (got !== exp) begin
        err_cnt++;
        $display("[TB] FAIL plain_run cycle %0d: got CEN/state/sc/done/busy=%b expected %b", n, got, exp);
      end
      if (n < 28) step;
    end
  endtask

  task automatic test_reload;
    logic [DW-1:0] a [4];
    logic [DW-1:0] b [4];
    logic [DW-1:0] expd;
    logic [1:0]    expw;
    int dcount, dt;
    for (int i = 0; i < 4; i++) begin
      a[i] = 64'hA000_0000_0000_00A0 + 64'(i);
      b[i] = 64'hB000_0000_0000_00B0 + 64'(i);
    end
    start = 1'b1; load_en = 1'b1;
    step;
    start = 1'b0; load_en = 1'b0;
    vec_cnt++;
    if ({host_if.hdata_ready, busy, CEN} !== 3'b111) begin
      err_cnt++;
      $display("[TB] FAIL collect_entry: got ready/busy/CEN=%b expected 111", {host_if.hdata_ready, busy, CEN});
    end
    for (int k = 0; k < 8; k++) begin
      host_if.hdata = (k < 4) ? a[k] : b[k-4];
      host_if.hdata_valid = 1'b1;
      step;
      host_if.hdata_valid = 1'b0;
      host_if.hdata = '0;
      if (k < 7) begin
        start = (k == 2);
        step;
        start = 1'b0;
        vec_cnt++;
        if ({host_if.hdata_ready, ROM3_w} !== 3'b100) begin
          err_cnt++;
          $display("[TB] FAIL collect_gap %0d: got ready/ROM3_w=%b expected 100", k, {host_if.hdata_ready, ROM3_w});
        end
      end
    end
    vec_cnt++;
    if (host_if.hdata_ready !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL ready_drop: got %b expected 0", host_if.hdata_ready);
    end
    for (int c = 0; c < 8; c++) begin
      expw = (c < 4) ? 2'd1 : 2'd2;
      expd = (c < 4) ? a[c] : b[c-4];
      vec_cnt++;
      if ({ROM3_w, horizontal_data_out} !== {expw, expd}) begin
        err_cnt++;
        $display("[TB] FAIL burst %0d: got w=%0d data=%h expected w=%0d data=%h", c, ROM3_w, horizontal_data_out, expw, expd);
      end
      step;
    end
    vec_cnt++;
    if ({ROM3_w, CEN, state, stage_counter} !== {2'd0, 1'b0, 4'd4, 3'd0}) begin
      err_cnt++;
      $display("[TB] FAIL burst_to_run: got w=%0d CEN=%b state=%0d sc=%0d expected 0 0 4 0", ROM3_w, CEN, state, stage_counter);
    end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if ({rom_hi[i], rom_lo[i]} !== {a[i], b[i]}) begin
        err_cnt++;
        $display("[TB] FAIL rom_word %0d: got %h_%h expected %h_%h", i, rom_hi[i], rom_lo[i], a[i], b[i]);
      end
    end
    dcount = 0; dt = -1;
    for (int t = 1; t <= 35; t++) begin
      if (done === 1'b1) begin dcount++; dt = t; end
      start = (t == 3);
      step;
    end
    start = 1'b0;
    vec_cnt++;
    if ({dcount, dt} !== {32'd1, 32'd27}) begin
      err_cnt++;
      $display("[TB] FAIL reload_done: got count=%0d at=%0d expected count=1 at=27", dcount, dt);
    end
    vec_cnt++;
    if (busy !== 1'b0) begin
      err_cnt++;
      $display("[TB] FAIL reload_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_hold;
    int act0, dcount, dt;
    act0 = 0; dcount = 0; dt = -1;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      if (t == 4) begin
        vec_cnt++;
        if ({CEN, state} !== {1'b0, 4'd4}) begin
          err_cnt++;
          $display("[TB] FAIL hold_pre: got CEN=%b state=%0d expected 0 4", CEN, state);
        end
      end
      if (t >= 5 && t <= 9) begin
        vec_cnt++;
        if ({CEN, state, stage_counter} !== {1'b1, 4'd4, 3'd0}) begin
          err_cnt++;
          $display("[TB] FAIL hold_cycle %0d: got CEN=%b state=%0d sc=%0d expected 1 4 0", t, CEN, state, stage_counter);
        end
      end
      if (t == 10) begin
        vec_cnt++;
        if ({CEN, state, stage_counter} !== {1'b0, 4'd6, 3'd0}) begin
          err_cnt++;
          $display("[TB] FAIL hold_resume: got CEN=%b state=%0d sc=%0d expected 0 6 0", CEN, state, stage_counter);
        end
      end
      if (CEN === 1'b0 && stage_counter === 3'd0) act0++;
      if (done === 1'b1) begin dcount++; dt = t; end
      hold = (t >= 4 && t <= 8);
      step;
    end
    hold = 1'b0;
    vec_cnt++;
    if (act0 !== 8) begin
      err_cnt++;
      $display("[TB] FAIL hold_active_count: got %0d expected 8", act0);
    end
    vec_cnt++;
    if ({dcount, dt} !== {32'd1, 32'd32}) begin
      err_cnt++;
      $display("[TB] FAIL hold_done: got count=%0d at=%0d expected count=1 at=32", dcount, dt);
    end
  endtask

  task automatic test_boundary;
    int dcount, dt, sc_max;
    dcount = 0; dt = -1; sc_max = 0;
    start = 1'b1;
    step;
    start = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      if (t == 26) begin
        vec_cnt++;
        if ({CEN, state, stage_counter} !== {1'b0, 4'd6, 3'd2}) begin
          err_cnt++;
          $display("[TB] FAIL last_cycle: got CEN=%b state=%0d sc=%0d expected 0 6 2", CEN, state, stage_counter);
        end
      end
      if (t >= 27 && t <= 29) begin
        vec_cnt++;
        if ({CEN, state, stage_counter, done} !== {1'b1, 4'd6, 3'd2, 1'b0}) begin
          err_cnt++;
          $display("[TB] FAIL final_hold %0d: got CEN=%b state=%0d sc=%0d done=%b expected 1 6 2 0", t, CEN, state, stage_counter, done);
        end
      end
      if (int'(stage_counter) > sc_max) sc_max = int'(stage_counter);
      if (done === 1'b1) begin dcount++; dt = t; end
      hold = (t >= 26 && t <= 28);
      step;
    end
    hold = 1'b0;
    vec_cnt++;
    if ({dcount, dt} !== {32'd1, 32'd30}) begin
      err_cnt++;
      $display("[TB] FAIL boundary_done: got count=%0d at=%0d expected count=1 at=30", dcount, dt);
    end
    vec_cnt++;
    if (sc_max !== 2) begin
      err_cnt++;
      $display("[TB] FAIL stage_max: got %0d expected 2", sc_max);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset;
    test_plain_run;
    test_reload;
    test_hold;
    test_boundary;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
